// File: rtl/adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq
// Description : Chunk-serial adder/subtractor. Adds two WIDTH-bit operands
//               CHUNK bits per clock, least-significant chunk first, with the
//               inter-chunk carry held in a register. Result, carry-out and
//               signed overflow are published together with a one-cycle done.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int c_steps = WIDTH / CHUNK;
    localparam int c_cntw  = (c_steps > 1) ? $clog2(c_steps) : 1;
    localparam logic [c_cntw-1:0] c_last = c_cntw'(c_steps - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_accept;
    logic                w_last;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_acc;
    logic                r_carry;
    logic [c_cntw-1:0]   r_cnt;

    logic [WIDTH-1:0]    r_s;
    logic                r_cout;
    logic                r_ovf;
    logic                r_done;

    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [CHUNK:0]      w_chunk;
    logic [CHUNK-1:0]    w_sum;
    logic                w_carry_msb;
    logic [WIDTH-1:0]    w_acc_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept a request when idle, leave RUN after last chunk
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One CHUNK-bit adder on the current chunk; the carry into the MSB is
    // recovered from the sum bit so no separate low-order adder is needed.
    always_comb begin
        w_a_chunk   = r_a[r_cnt*CHUNK +: CHUNK];
        w_b_chunk   = r_b[r_cnt*CHUNK +: CHUNK];
        w_chunk     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum       = w_chunk[CHUNK-1:0];
        w_carry_msb = w_sum[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];
        w_acc_next  = r_acc;
        w_acc_next[r_cnt*CHUNK +: CHUNK] = w_sum;
    end

    // Operand capture, chunk stepping and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= sub ? ~B : B;
                r_carry <= sub ? 1'b1 : cin;
                r_cnt   <= '0;
                r_acc   <= '0;
            end else if (r_state == ST_RUN) begin
                r_acc   <= w_acc_next;
                r_carry <= w_chunk[CHUNK];
                r_cnt   <= r_cnt + c_cntw'(1);
                if (w_last) begin
                    r_s    <= w_acc_next;
                    r_cout <= w_chunk[CHUNK];
                    r_ovf  <= w_carry_msb ^ w_chunk[CHUNK];
                end
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign S    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_seq
// Description : Scoreboard bench for adder_seq (WIDTH=16, CHUNK=4). Stimulus
//               pushes hand-computed results; a monitor pops them on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        busy, done, cout, ovf;
    logic [15:0] S;

    adder_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
        .sub(sub), .busy(busy), .done(done), .S(S), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    logic [15:0] hold_s = '0;
    logic        hold_c = 1'b0;
    logic        hold_o = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop the scoreboard on every done, otherwise outputs must hold
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("S", {16'd0, S}, {16'd0, e.s});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_in_done", {31'd0, busy}, 32'd0);
                end
                hold_s = S;
                hold_c = cout;
                hold_o = ovf;
            end else begin
                chk("S_hold", {16'd0, S}, {16'd0, hold_s});
                chk("flags_hold", {30'd0, cout, ovf}, {30'd0, hold_c, hold_o});
            end
        end
    end

    // Drive a request at the current negedge; it is accepted at the next edge
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input bit push, input string tag);
        A = a; B = b; cin = ci; sub = sb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_accepted"}, {31'd0, busy}, 32'd1);
        if (push) q.push_back('{s: es, c: ec, o: eo, cyc: cyc + 4});
    endtask

    // Wait (bounded) for busy to drop; returns at the done-cycle negedge
    task automatic wait_idle(output int nb);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
            else break;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_S", {16'd0, S}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1, "basic");
        wait_idle(nb);
        chk("busy_cycles", nb, 32'd4);
        @(negedge clk);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "carry_all");
        wait_idle(nb);
        @(negedge clk);
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, "cin");
        wait_idle(nb);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, "ovf_add");
        wait_idle(nb);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, "ovf_sub");
        wait_idle(nb);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, "borrow");
        wait_idle(nb);
        issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, "no_borrow");
        wait_idle(nb);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, "neg_ovf");
        wait_idle(nb);

        // Back-to-back: second request driven in the done cycle
        @(negedge clk);
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1, "b2b_first");
        wait_idle(nb);
        issue(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "b2b_second");
        wait_idle(nb);

        // Start re-asserted with junk operands during RUN must be ignored
        @(negedge clk);
        issue(16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 16'hB4B4, 1'b0, 1'b0, 1'b1, "noise");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                start = 1'b1;
                A = 16'($urandom);
                B = 16'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end else begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("noise_not_queued", {31'd0, busy}, 32'd0);

        // Reset two cycles into RUN discards the operation
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "aborted");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_s = '0;
        hold_c = 1'b0;
        hold_o = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_S", {16'd0, S}, 32'd0);
        chk("abort_flags", {30'd0, cout, ovf}, 32'd0);
        repeat (8) @(negedge clk);
        issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b1, "after_rst");
        wait_idle(nb);
        chk("after_rst_busy_cycles", nb, 32'd4);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
